uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART transmitter among `NREQ` byte-producing requesters. It grants one requester at a time and issues that requester's byte to the transmitter. It waits for the transmitter to accept the byte and finish the frame before granting again. It also produces the 16x-oversampling tick enable (`tick16`) that drives the UART core's bit timing. It sits between the on-chip byte sources and the UART core's `tx_data`/`tx_req`/`tx_busy` port.

---
 rtl/uart_tx_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin scheduler sharing one UART transmitter among
//                NREQ byte producers, plus the 16x oversampling tick source.
//
//  Ports
//    clk           in   system clock
//    rst           in   asynchronous active-high reset
//    div_val       in   tick16 period minus one, in clk cycles
//    req           in   per-requester byte pending (held until its ack)
//    req_data      in   byte of requester i at [8i+7:8i]
//    ack           out  one-cycle pulse: byte of requester i captured
//    core_tx_data  out  byte presented to the UART core
//    core_tx_req   out  one-cycle start strobe to the UART core
//    core_tx_busy  in   UART core busy flag
//    tick16        out  one-cycle oversampling enable
//    owner         out  index of the current / last granted requester
//    active        out  high whenever the scheduler is not idle
//    timeout_err   out  sticky: core never went busy after a strobe
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIV_W-1:0]          div_val,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*8-1:0]         req_data,
    output logic [NREQ-1:0]           ack,
    output logic [7:0]                core_tx_data,
    output logic                      core_tx_req,
    input  logic                      core_tx_busy,
    output logic                      tick16,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      active,
    output logic                      timeout_err
);

    localparam int OWN_W = $clog2(NREQ);

    localparam logic [OWN_W-1:0] c_LAST_RST = OWN_W'(NREQ - 1);
    localparam logic [1:0]       c_WDOG_MAX = 2'd3;
    localparam logic [NREQ-1:0]  c_ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [OWN_W-1:0]   r_last;
    logic [OWN_W-1:0]   r_owner;
    logic [7:0]         r_hold;
    logic [NREQ-1:0]    r_ack;
    logic               r_tx_req;
    logic               r_timeout;
    logic [1:0]         r_wdog;
    logic [DIV_W-1:0]   r_cnt;
    logic               r_tick;

    logic [OWN_W-1:0]   w_sel_lo;
    logic [OWN_W-1:0]   w_sel_hi;
    logic               w_hit_hi;
    logic [OWN_W-1:0]   w_sel;
    logic [7:0]         w_sel_data;
    logic               w_any;

    // ------------------------------------------------------------------------
    // Tick generator. The >= compare lets a reduced div_val take effect at
    // once instead of waiting for the counter to wrap through its full range.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt >= div_val) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Round-robin pick: the lowest requesting index above r_last wins; if none
    // is above it, the search wraps to the lowest requesting index overall.
    // The descending loop lets the lowest matching index overwrite the others.
    // ------------------------------------------------------------------------
    assign w_any = |req;

    always_comb begin
        w_sel_lo = '0;
        w_sel_hi = '0;
        w_hit_hi = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_sel_lo = OWN_W'(k);
            end
            if (req[k] && (OWN_W'(k) > r_last)) begin
                w_sel_hi = OWN_W'(k);
                w_hit_hi = 1'b1;
            end
        end
    end

    assign w_sel = w_hit_hi ? w_sel_hi : w_sel_lo;

    always_comb begin
        w_sel_data = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            if (w_sel == OWN_W'(k)) begin
                w_sel_data = req_data[8*k +: 8];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Grant / issue / wait state machine. Strobe and ack are raised on the
    // grant edge so they are high exactly while the FSM sits in ISSUE.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last    <= c_LAST_RST;
            r_owner   <= '0;
            r_hold    <= 8'h00;
            r_ack     <= '0;
            r_tx_req  <= 1'b0;
            r_timeout <= 1'b0;
            r_wdog    <= 2'd0;
        end else begin
            r_tx_req <= 1'b0;
            r_ack    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_hold   <= w_sel_data;
                        r_last   <= w_sel;
                        r_owner  <= w_sel;
                        r_tx_req <= 1'b1;
                        r_ack    <= c_ONE_HOT0 << w_sel;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= 2'd0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (core_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_wdog == c_WDOG_MAX) begin
                        // Fourth consecutive cycle without busy: give up.
                        r_timeout <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 2'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!core_tx_busy) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack          = r_ack;
    assign core_tx_data = r_hold;
    assign core_tx_req  = r_tx_req;
    assign tick16       = r_tick;
    assign owner        = r_owner;
    assign timeout_err  = r_timeout;
    assign active       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter with a transaction
//                level round-robin model, a UART core model and requesters.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int DIV_W = 16;
    localparam int OWN_W = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DIV_W-1:0]      div_val;
    logic [NREQ-1:0]       req;
    logic [NREQ*8-1:0]     req_data;
    logic [NREQ-1:0]       ack;
    logic [7:0]            core_tx_data;
    logic                  core_tx_req;
    logic                  core_tx_busy;
    logic                  tick16;
    logic [OWN_W-1:0]      owner;
    logic                  active;
    logic                  timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc  = 0;

    // reference model state
    int         m_last;
    logic [7:0] m_hold;
    logic       m_err;
    logic [7:0] bytes [NREQ];
    int         keep_mode [NREQ];   // 0 drop after ack, 1 keep same byte, 2 random

    // UART core model
    logic cfg_rand;
    logic cfg_never;
    int   cfg_d;
    int   cfg_len;
    logic bz_en;
    int   bz_start;
    int   bz_end;

    logic strobe_seen;
    int   strobe_idx;
    logic prev_req;
    logic tick_en;
    int   last_tick;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ  (NREQ),
        .DIV_W (DIV_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .div_val      (div_val),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .core_tx_data (core_tx_data),
        .core_tx_req  (core_tx_req),
        .core_tx_busy (core_tx_busy),
        .tick16       (tick16),
        .owner        (owner),
        .active       (active),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, ncyc);
        end
    endtask

    // First requesting index searching upward from last+1, modulo NREQ.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (r[idx] == 1'b1) return idx;
        end
        return -1;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = bytes[i];
    endtask

    // One clock cycle: observe at the falling edge, check, then let the
    // requesters and the core model react.
    task automatic cyc();
        int exp_idx;
        int d;
        int len;
        logic never;
        @(negedge clk);
        ncyc++;
        if (core_tx_req || (ack != '0))
            chk("ack_with_strobe", 32'(ack != '0), 32'(core_tx_req));
        if (core_tx_req) begin
            chk("strobe_width", 32'(prev_req), 0);
            exp_idx = rr_pick(req, m_last);
            if (exp_idx < 0) begin
                chk("grant_without_req", 1, 0);
            end else begin
                chk("grant_owner", 32'(owner), exp_idx);
                chk("grant_ack", 32'(ack), 32'(1) << exp_idx);
                chk("grant_data", 32'(core_tx_data), 32'(bytes[exp_idx]));
                chk("err_sticky", 32'(timeout_err), 32'(m_err));
                chk("active_issue", 32'(active), 1);
                m_last = exp_idx;
                m_hold = bytes[exp_idx];
                case (keep_mode[exp_idx])
                    1: ;
                    2: begin
                        if ($urandom_range(0, 1) == 1) bytes[exp_idx] = 8'($urandom);
                        else req[exp_idx] = 1'b0;
                    end
                    default: req[exp_idx] = 1'b0;
                endcase
                drive_data();
                if (cfg_rand) begin
                    never = ($urandom_range(0, 7) == 0);
                    d     = $urandom_range(0, 4);
                    len   = $urandom_range(1, 8);
                end else begin
                    never = cfg_never;
                    d     = cfg_d;
                    len   = cfg_len;
                end
                if (never) begin
                    bz_en = 1'b0;
                    m_err = 1'b1;
                end else begin
                    bz_en    = 1'b1;
                    bz_start = ncyc + d;
                    bz_end   = bz_start + len;
                end
            end
            strobe_seen = 1'b1;
            strobe_idx  = exp_idx;
        end else begin
            chk("data_hold", 32'(core_tx_data), 32'(m_hold));
        end
        core_tx_busy = bz_en && (ncyc >= bz_start) && (ncyc < bz_end);
        if (tick_en && tick16) begin
            if (last_tick >= 0) chk("tick_period", ncyc - last_tick, int'(div_val) + 1);
            last_tick = ncyc;
        end
        prev_req = core_tx_req;
    endtask

    task automatic wait_strobe(input string tag, output int idx);
        int n;
        n = 0;
        strobe_seen = 1'b0;
        while (!strobe_seen && n < 200) begin
            cyc();
            n++;
        end
        if (!strobe_seen) chk({tag, "_strobe_bound"}, 0, 1);
        idx = strobe_idx;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (((req != '0) || active || core_tx_busy) && n < 3000) begin
            cyc();
            n++;
        end
        chk({tag, "_idle_bound"}, 32'((req != '0) || active), 0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must drop at once.
    task automatic do_reset(input int ncycles);
        #2;
        rst          = 1'b1;
        bz_en        = 1'b0;
        core_tx_busy = 1'b0;
        m_last       = NREQ - 1;
        m_hold       = 8'h00;
        m_err        = 1'b0;
        prev_req     = 1'b0;
        #1;
        chk("arst_active", 32'(active), 0);
        chk("arst_strobe", 32'(core_tx_req), 0);
        chk("arst_ack", 32'(ack), 0);
        chk("arst_data", 32'(core_tx_data), 0);
        chk("arst_tick", 32'(tick16), 0);
        chk("arst_err", 32'(timeout_err), 0);
        chk("arst_owner", 32'(owner), 0);
        repeat (ncycles) cyc();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int idx;
        rst          = 1'b1;
        div_val      = 16'd3;
        req          = '0;
        core_tx_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            bytes[i]     = 8'h00;
            keep_mode[i] = 0;
        end
        drive_data();
        cfg_rand  = 1'b0;
        cfg_never = 1'b0;
        cfg_d     = 1;
        cfg_len   = 4;
        bz_en     = 1'b0;
        bz_start  = 0;
        bz_end    = 0;
        m_last    = NREQ - 1;
        m_hold    = 8'h00;
        m_err     = 1'b0;
        prev_req  = 1'b0;
        tick_en   = 1'b0;
        last_tick = -1;
        strobe_seen = 1'b0;
        strobe_idx  = -1;

        // ---- reset values and tick after release ----
        repeat (3) begin
            cyc();
            chk("rst_ack", 32'(ack), 0);
            chk("rst_strobe", 32'(core_tx_req), 0);
            chk("rst_data", 32'(core_tx_data), 0);
            chk("rst_tick", 32'(tick16), 0);
            chk("rst_active", 32'(active), 0);
            chk("rst_err", 32'(timeout_err), 0);
            chk("rst_owner", 32'(owner), 0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            chk("tick_div3", 32'(tick16), 32'(c % 4 == 0));
        end

        // ---- single request ----
        cfg_d     = 1;
        cfg_len   = 20;
        bytes[0]  = 8'hA5;
        drive_data();
        req       = 4'b0001;
        cyc();
        chk("single_strobe", 32'(core_tx_req), 1);
        chk("single_ack", 32'(ack), 1);
        chk("single_data", 32'(core_tx_data), 32'hA5);
        cyc();
        chk("single_strobe_low", 32'(core_tx_req), 0);
        chk("single_ack_low", 32'(ack), 0);
        while (ncyc < bz_end) cyc();
        chk("single_active_at_fall", 32'(active), 1);
        cyc();
        chk("single_active_drop", 32'(active), 0);

        // ---- round robin with all requesters held ----
        do_reset(2);
        for (int i = 0; i < NREQ; i++) begin
            bytes[i]     = 8'(8'h10 + i);
            keep_mode[i] = 1;
        end
        drive_data();
        cfg_d   = 1;
        cfg_len = 3;
        req     = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_strobe("rr", idx);
            chk("rr_owner", idx, k % NREQ);
            chk("rr_data", 32'(core_tx_data), 32'(8'h10 + (k % NREQ)));
        end
        for (int i = 0; i < NREQ; i++) keep_mode[i] = 0;
        wait_idle("rr");

        // ---- fairness after service ----
        do_reset(2);
        for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
        drive_data();
        req = 4'b0100;
        wait_strobe("fair_a", idx);
        chk("fair_first", idx, 2);
        wait_idle("fair_a");
        req = 4'b0101;
        wait_strobe("fair_b", idx);
        chk("fair_wrap", idx, 0);
        wait_strobe("fair_c", idx);
        chk("fair_then", idx, 2);
        wait_idle("fair_b");

        // ---- timeout ----
        do_reset(2);
        cfg_never = 1'b1;
        req       = 4'b0001;
        wait_strobe("to", idx);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            chk("to_err", 32'(timeout_err), 32'(c == 5));
            chk("to_active", 32'(active), 32'(c < 5));
        end
        cfg_never = 1'b0;
        cfg_d     = 2;
        cfg_len   = 4;
        req       = 4'b0010;
        wait_strobe("to_next", idx);
        wait_idle("to_next");
        chk("to_sticky", 32'(timeout_err), 1);

        // ---- reset mid-frame with a pending request ----
        do_reset(2);
        cfg_d   = 1;
        cfg_len = 30;
        req     = 4'b0010;
        wait_strobe("mf", idx);
        chk("mf_pre_owner", idx, 1);
        repeat (4) cyc();
        req = 4'b0110;
        repeat (2) cyc();
        chk("mf_active_before", 32'(active), 1);
        do_reset(2);
        wait_strobe("mf_a", idx);
        chk("mf_first", idx, 1);
        wait_strobe("mf_b", idx);
        chk("mf_second", idx, 2);
        wait_idle("mf");

        // ---- divider change mid-count ----
        div_val = 16'd15;
        do_reset(2);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            chk("div15_quiet", 32'(tick16), 0);
        end
        div_val = 16'd2;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            chk("div_shrink", 32'(tick16), 32'(c % 3 == 1));
        end
        div_val = 16'd0;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chk("div0", 32'(tick16), 1);
        end

        // ---- randomized traffic ----
        do_reset(2);
        cfg_rand = 1'b1;
        for (int i = 0; i < NREQ; i++) keep_mode[i] = 2;
        div_val = 16'($urandom_range(0, 9));
        repeat (20) cyc();
        tick_en   = 1'b1;
        last_tick = -1;
        for (int it = 0; it < 1500; it++) begin
            if ((req == '0) && ($urandom_range(0, 3) == 0)) begin
                for (int i = 0; i < NREQ; i++) bytes[i] = 8'($urandom);
                drive_data();
                req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            end
            cyc();
        end
        for (int i = 0; i < NREQ; i++) keep_mode[i] = 0;
        wait_idle("rand");
        chk("rand_err", 32'(timeout_err), 32'(m_err));
        chk("rand_tick_seen", 32'(last_tick >= 0), 1);
        tick_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
